// File: rtl/bitcol_weight_sequencer.sv
// Bit-column weight sequencer: turns a group of signed weights into one MAC
// control word per non-zero bit column, lowest column first.
module bitcol_weight_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int VEC_LENGTH    = 8,
  parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH),
  parameter int SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]        w_in,
  input  logic [SUM_ACT_WIDTH-1:0]                     sum_act_in,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         en,
  output logic                                         load_accum,
  output logic                                         last,
  output logic [VEC_LENGTH/2-1:0][MUX_SEL_WIDTH-1:0]   act_sel,
  output logic [VEC_LENGTH/2-1:0]                      act_val,
  output logic [SUM_ACT_WIDTH-1:0]                     sum_act,
  output logic [2:0]                                   mul_const,
  output logic                                         is_shift_mul,
  output logic [2:0]                                   column_idx,
  output logic                                         is_msb,
  output logic                                         is_skip_zero
);

  localparam int LANES  = VEC_LENGTH / 2;
  localparam int LANE_W = $clog2(LANES);
  localparam int COL_W  = $clog2(DATA_WIDTH);
  localparam int POP_W  = $clog2(VEC_LENGTH + 1);

  typedef enum logic {
    S_IDLE,
    S_ISSUE
  } state_t;

  state_t                                     r_state;
  state_t                                     w_state_next;
  logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]      r_cols;
  logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0]      w_cols_in;
  logic [DATA_WIDTH-1:0]                      r_remain;
  logic [DATA_WIDTH-1:0]                      w_remain_in;
  logic [DATA_WIDTH-1:0]                      w_remain_next;
  logic [DATA_WIDTH-1:0]                      w_cur_onehot;
  logic                                       r_first;
  logic [SUM_ACT_WIDTH-1:0]                   r_sum;
  logic [COL_W-1:0]                           w_col;
  logic [VEC_LENGTH-1:0]                      w_mask;
  logic [VEC_LENGTH-1:0]                      w_target;
  logic [POP_W-1:0]                           w_pop;
  logic [LANE_W:0]                            w_n;
  logic [LANES-1:0][MUX_SEL_WIDTH-1:0]        w_sel;
  logic [LANES-1:0]                           w_val;
  logic                                       w_skip;
  logic                                       w_last;
  logic                                       w_accept;

  // Transpose the incoming weights into column masks and flag non-empty columns.
  always_comb begin
    w_cols_in   = '0;
    w_remain_in = '0;
    for (int c = 0; c < DATA_WIDTH; c++) begin
      for (int k = 0; k < VEC_LENGTH; k++) begin
        w_cols_in[c][k] = w_in[k][c];
      end
      w_remain_in[c] = |w_cols_in[c];
    end
  end

  // Lowest remaining column wins; an empty mask falls back to column 0 (null word).
  always_comb begin
    w_col        = '0;
    w_cur_onehot = '0;
    for (int c = DATA_WIDTH - 1; c >= 0; c--) begin
      if (r_remain[c]) begin
        w_col           = COL_W'(c);
        w_cur_onehot    = '0;
        w_cur_onehot[c] = 1'b1;
      end
    end
    w_remain_next = r_remain & ~w_cur_onehot;
    w_last        = (w_remain_next == '0);
    w_mask        = r_cols[w_col];
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < VEC_LENGTH; k++) begin
      w_pop = w_pop + POP_W'(w_mask[k]);
    end
    w_skip   = (w_pop <= POP_W'(LANES));
    w_target = w_skip ? w_mask : ~w_mask;
    w_sel    = '0;
    w_val    = '0;
    w_n      = '0;
    for (int k = 0; k < VEC_LENGTH; k++) begin
      if (w_target[k] && (int'(w_n) < LANES)) begin
        w_sel[w_n[LANE_W-1:0]] = MUX_SEL_WIDTH'(k - int'(w_n));
        w_val[w_n[LANE_W-1:0]] = 1'b1;
        w_n                    = w_n + 1'b1;
      end
    end
  end

  // A new group may land in the same cycle the final word is consumed.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      S_IDLE: in_ready = 1'b1;
      S_ISSUE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & w_last;
        if (out_ready && w_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    w_accept = in_valid & in_ready;
    if (w_accept) begin
      w_state_next = S_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cols   <= '0;
      r_remain <= '0;
      r_first  <= 1'b0;
      r_sum    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_cols   <= w_cols_in;
        r_remain <= w_remain_in;
        r_first  <= 1'b1;
        r_sum    <= sum_act_in;
      end else if (out_valid && out_ready) begin
        r_remain <= w_remain_next;
        r_first  <= 1'b0;
      end
    end
  end

  assign en           = out_valid & out_ready;
  assign load_accum   = out_valid & r_first;
  assign last         = out_valid & w_last;
  assign act_sel      = out_valid ? w_sel : '0;
  assign act_val      = out_valid ? w_val : '0;
  assign column_idx   = out_valid ? 3'(w_col) : 3'd0;
  assign is_msb       = out_valid & (w_col == COL_W'(DATA_WIDTH - 1));
  assign is_skip_zero = out_valid & w_skip;
  assign sum_act      = r_sum;
  assign mul_const    = 3'd0;
  assign is_shift_mul = 1'b0;

endmodule

// File: tb/tb_bitcol_weight_sequencer.sv
// Testbench for bitcol_weight_sequencer: directed plan steps plus random groups,
// checked against a queue-based model of the expected control words.
module tb_bitcol_weight_sequencer;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0][7:0]       w_in;
  logic [10:0]           sum_act_in;
  logic                  out_valid;
  logic                  out_ready;
  logic                  en;
  logic                  load_accum;
  logic                  last;
  logic [3:0][2:0]       act_sel;
  logic [3:0]            act_val;
  logic [10:0]           sum_act;
  logic [2:0]            mul_const;
  logic                  is_shift_mul;
  logic [2:0]            column_idx;
  logic                  is_msb;
  logic                  is_skip_zero;

  bitcol_weight_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .w_in(w_in), .sum_act_in(sum_act_in), .out_valid(out_valid),
    .out_ready(out_ready), .en(en), .load_accum(load_accum), .last(last),
    .act_sel(act_sel), .act_val(act_val), .sum_act(sum_act),
    .mul_const(mul_const), .is_shift_mul(is_shift_mul),
    .column_idx(column_idx), .is_msb(is_msb), .is_skip_zero(is_skip_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      col;
    logic            skip;
    logic [3:0][2:0] sel;
    logic [3:0]      val;
    logic            load;
    logic            last;
  } word_t;

  word_t           expQ[$];
  logic [7:0][7:0] pendW[$];
  logic [10:0]     pendS[$];
  bit              readyQ[$];
  logic [10:0]     expSum;
  int              checks = 0;
  int              failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane i addresses the i-th target activation; targets are ones when sparse, zeros when dense.
  function automatic word_t encodeCol(input logic [7:0] mask, input int c);
    word_t wd;
    int    tq[$];
    wd      = '0;
    wd.col  = 3'(c);
    wd.skip = ($countones(mask) <= 4);
    for (int k = 0; k < 8; k++) if (mask[k] == wd.skip) tq.push_back(k);
    for (int i = 0; i < tq.size() && i < 4; i++) begin
      wd.sel[i] = 3'(tq[i] - i);
      wd.val[i] = 1'b1;
    end
    return wd;
  endfunction

  function automatic void buildWords(input logic [7:0][7:0] w);
    int         cols[$];
    logic [7:0] masks[8];
    word_t      wd;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 8; k++) masks[c][k] = w[k][c];
      if (masks[c] != 0) cols.push_back(c);
    end
    if (cols.size() == 0) begin
      wd      = '0;
      wd.skip = 1'b1;
      wd.load = 1'b1;
      wd.last = 1'b1;
      expQ.push_back(wd);
    end else begin
      foreach (cols[i]) begin
        wd      = encodeCol(masks[cols[i]], cols[i]);
        wd.load = (i == 0);
        wd.last = (i == cols.size() - 1);
        expQ.push_back(wd);
      end
    end
  endfunction

  task automatic applyStimulus(input bit offer, input bit rdy);
    in_valid  = offer;
    out_ready = rdy;
    if (offer) begin
      w_in       = pendW[0];
      sum_act_in = pendS[0];
    end else begin
      w_in       = {$urandom, $urandom};
      sum_act_in = 11'($urandom);
    end
  endtask

  task automatic checkOutput(input bit expValid, input word_t h, input bit expReady);
    check("out_valid", out_valid, expValid);
    check("in_ready", in_ready, expReady);
    check("en", en, expValid & out_ready);
    check("mul_const", mul_const, 0);
    check("is_shift_mul", is_shift_mul, 0);
    if (expValid) begin
      check("load_accum", load_accum, h.load);
      check("last", last, h.last);
      check("column_idx", column_idx, h.col);
      check("is_msb", is_msb, h.col == 3'd7);
      check("is_skip_zero", is_skip_zero, h.skip);
      check("act_sel", act_sel, h.sel);
      check("act_val", act_val, h.val);
      check("sum_act", sum_act, expSum);
    end
  endtask

  task automatic checkResetState();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_en", en, 0);
    check("rst_load_accum", load_accum, 0);
    check("rst_last", last, 0);
    check("rst_act_sel", act_sel, 0);
    check("rst_act_val", act_val, 0);
    check("rst_sum_act", sum_act, 0);
    check("rst_column_idx", column_idx, 0);
    check("rst_is_msb", is_msb, 0);
    check("rst_is_skip_zero", is_skip_zero, 0);
  endtask

  task automatic stepCycle(input bit offer, input bit rdy);
    bit    expValid, expReady, accept, consume;
    word_t h;
    @(negedge clk);
    applyStimulus(offer && (pendW.size() > 0), rdy);
    #1;
    expValid = (expQ.size() > 0);
    h        = expValid ? expQ[0] : '0;
    expReady = !expValid || (rdy && h.last);
    checkOutput(expValid, h, expReady);
    accept  = in_valid && expReady;
    consume = expValid && rdy;
    @(posedge clk);
    if (consume) expQ.delete(0);
    if (accept) begin
      buildWords(pendW[0]);
      expSum = pendS[0];
      pendW.delete(0);
      pendS.delete(0);
    end
  endtask

  task automatic runUntilDrained(input bit rndReady, input bit rndOffer);
    int cyc = 0;
    bit rdy, offer;
    while ((pendW.size() > 0 || expQ.size() > 0) && cyc < 3000) begin
      if (readyQ.size() > 0 && expQ.size() > 0) begin
        rdy = readyQ.pop_front();
      end else begin
        rdy = rndReady ? bit'($urandom_range(0, 1)) : 1'b1;
      end
      offer = rndOffer ? bit'($urandom_range(0, 1)) : 1'b1;
      stepCycle(offer, rdy);
      cyc++;
    end
    check("drain_timeout", pendW.size() + expQ.size(), 0);
    stepCycle(1'b0, 1'b1);
  endtask

  task automatic queueGroup(input logic [7:0][7:0] w, input logic [10:0] s);
    pendW.push_back(w);
    pendS.push_back(s);
  endtask

  initial begin
    logic [7:0][7:0] gw;
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    w_in       = '0;
    sum_act_in = '0;
    expSum     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkResetState();

    // All weights 0x01: single dense column 0.
    gw = {8{8'h01}};
    queueGroup(gw, 11'h123);
    runUntilDrained(1'b0, 1'b0);

    // Only the sign bit of w[0]: single MSB column.
    gw    = '0;
    gw[0] = 8'h80;
    queueGroup(gw, 11'h7FF);
    runUntilDrained(1'b0, 1'b0);

    // Column 2 mask 0b10110100.
    gw    = '0;
    gw[2] = 8'h04;
    gw[4] = 8'h04;
    gw[5] = 8'h04;
    gw[7] = 8'h04;
    queueGroup(gw, 11'h055);
    runUntilDrained(1'b0, 1'b0);

    // Columns {0,3,7} under stalls.
    gw    = '0;
    gw[0] = 8'h89;
    queueGroup(gw, 11'h2AA);
    readyQ = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    runUntilDrained(1'b0, 1'b0);

    // Back-to-back: A with columns {1,5}, then an all-zero group B.
    gw    = '0;
    gw[1] = 8'h22;
    queueGroup(gw, 11'h011);
    gw = '0;
    queueGroup(gw, 11'h022);
    runUntilDrained(1'b0, 1'b0);

    // Reset while the second of four columns is pending, with in_valid also high.
    gw    = '0;
    gw[3] = 8'h55;
    queueGroup(gw, 11'h3C3);
    stepCycle(1'b1, 1'b1);
    stepCycle(1'b0, 1'b1);
    @(negedge clk);
    reset      = 1'b1;
    in_valid   = 1'b1;
    w_in       = {8{8'hFF}};
    sum_act_in = 11'h5A5;
    out_ready  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    expQ.delete();
    expSum = '0;
    #1;
    checkResetState();
    stepCycle(1'b0, 1'b1);
    gw    = '0;
    gw[6] = 8'h0C;
    queueGroup(gw, 11'h0F0);
    runUntilDrained(1'b0, 1'b0);

    // Random groups with random sparsity, offers and backpressure.
    for (int g = 0; g < 40; g++) begin
      for (int k = 0; k < 8; k++) begin
        gw[k] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
        if (g % 3 == 1) gw[k] = gw[k] & 8'($urandom);
      end
      if (g % 7 == 0) gw = '0;
      queueGroup(gw, 11'($urandom));
    end
    runUntilDrained(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
